// File: rtl/ped_crossing.sv
// ped_crossing -- pedestrian-side unit of the traffic controller ped/light link.
//
// Debounces a raw push button, raises ped_req toward the traffic controller,
// waits for the controller to report RED, then runs the steady WALK phase,
// the flashing DONT_WALK phase and a cooldown before another request may rise.
//
// Optional feature: define PED_TIMEOUT_EN to give up on a request that has not
// seen RED within REQ_TIMEOUT cycles (req_timeout pulses, back to IDLE).
// Without the macro REQ waits indefinitely and req_timeout is tied low.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   btn          in   raw asynchronous pedestrian button
//   light_state  in   controller state code (RED = 3'b011, anything else is not RED)
//   ped_req      out  request to the controller, held through the crossing
//   walk         out  steady WALK lamp
//   dont_walk    out  DONT_WALK lamp, steady or flashing
//   countdown    out  remaining cycles in WALK/FLASH/COOLDOWN, 0 otherwise
//   req_pending  out  a press was latched during COOLDOWN (or on an abort)
//   abort        out  one-cycle pulse when a crossing is cut short
//   req_timeout  out  one-cycle pulse on request timeout
//
// All outputs are registered.

module ped_crossing #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int WALK_CYC     = 20,
  parameter int FLASH_CYC    = 10,
  parameter int FLASH_HALF   = 2,
  parameter int COOLDOWN_CYC = 30,
  parameter int REQ_TIMEOUT  = 64,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn,
  input  logic [2:0]       light_state,
  output logic             ped_req,
  output logic             walk,
  output logic             dont_walk,
  output logic [CNT_W-1:0] countdown,
  output logic             req_pending,
  output logic             abort,
  output logic             req_timeout
);

  // Every phase length must be at least one cycle and its reload value must
  // fit in the countdown; the counter is reloaded on each phase entry and
  // therefore never wraps.
  if (DEBOUNCE_CYC < 1 || WALK_CYC < 1 || FLASH_CYC < 1 || FLASH_HALF < 1 ||
      COOLDOWN_CYC < 1 || REQ_TIMEOUT < 1 ||
      WALK_CYC > 2**CNT_W || FLASH_CYC > 2**CNT_W ||
      COOLDOWN_CYC > 2**CNT_W) begin : g_param_check
    $error("ped_crossing: phase lengths must be >= 1 and fit in CNT_W bits");
  end

  localparam logic [2:0]       LIGHT_RED  = 3'b011;
  localparam int               DEB_W      = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DEB_W-1:0] DEB_MAX    = DEB_W'(DEBOUNCE_CYC);
  localparam int               HALF_W     = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(FLASH_HALF - 1);
  localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYC - 1);
  localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_CYC - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD  = CNT_W'(COOLDOWN_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WALK,
    S_FLASH,
    S_COOLDOWN
  } state_t;

  // ---------------------------------------------------------------------------
  // Button path: 2-flop synchroniser, saturating debounce counter, and a
  // registered one-cycle press pulse on the cycle the counter reaches
  // DEBOUNCE_CYC. Holding the button keeps the counter saturated, so a long
  // press yields a single pulse.
  // ---------------------------------------------------------------------------
  logic             btn_meta_q;
  logic             btn_sync_q;
  logic [DEB_W-1:0] deb_cnt_q;
  logic [DEB_W-1:0] deb_cnt_d;
  logic             press_q;

  always_comb begin
    deb_cnt_d = '0;
    if (btn_sync_q) begin
      deb_cnt_d = (deb_cnt_q == DEB_MAX) ? DEB_MAX : deb_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      deb_cnt_q  <= '0;
      press_q    <= 1'b0;
    end else begin
      btn_meta_q <= btn;
      btn_sync_q <= btn_meta_q;
      deb_cnt_q  <= deb_cnt_d;
      press_q    <= (deb_cnt_d == DEB_MAX) && (deb_cnt_q != DEB_MAX);
    end
  end

  // ---------------------------------------------------------------------------
  // Crossing state machine with registered lamp/request outputs.
  // ---------------------------------------------------------------------------
  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [HALF_W-1:0] half_q;
  logic              ped_req_q;
  logic              walk_q;
  logic              dont_walk_q;
  logic              pending_q;
  logic              abort_q;
  logic              light_red;

`ifdef PED_TIMEOUT_EN
  localparam int              WAIT_W    = (REQ_TIMEOUT > 1) ? $clog2(REQ_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(REQ_TIMEOUT - 1);
  logic [WAIT_W-1:0] wait_q;
  logic              timeout_q;
`endif

  assign light_red = (light_state == LIGHT_RED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      half_q      <= '0;
      ped_req_q   <= 1'b0;
      walk_q      <= 1'b0;
      dont_walk_q <= 1'b1;
      pending_q   <= 1'b0;
      abort_q     <= 1'b0;
`ifdef PED_TIMEOUT_EN
      wait_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      abort_q <= 1'b0;
`ifdef PED_TIMEOUT_EN
      // The wait counter only advances in REQ, so it is zero on every entry.
      timeout_q <= 1'b0;
      wait_q    <= '0;
`endif
      case (state_q)
        S_IDLE: begin
          if (press_q) begin
            state_q   <= S_REQ;
            ped_req_q <= 1'b1;
          end
        end

        S_REQ: begin
          // RED takes priority over a timeout expiring in the same cycle.
          if (light_red) begin
            state_q     <= S_WALK;
            cnt_q       <= WALK_LOAD;
            walk_q      <= 1'b1;
            dont_walk_q <= 1'b0;
          end
`ifdef PED_TIMEOUT_EN
          else if (wait_q == WAIT_LAST) begin
            state_q   <= S_IDLE;
            ped_req_q <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
`endif
        end

        S_WALK, S_FLASH: begin
          if (!light_red) begin
            // Lost RED mid-crossing: bail out to a steady DONT_WALK cooldown.
            // Checked first so it also wins over a phase expiring this cycle.
            state_q     <= S_COOLDOWN;
            cnt_q       <= COOL_LOAD;
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
            ped_req_q   <= 1'b0;
            abort_q     <= 1'b1;
            pending_q   <= press_q;
          end else if (cnt_q == '0) begin
            if (state_q == S_WALK) begin
              state_q     <= S_FLASH;
              cnt_q       <= FLASH_LOAD;
              walk_q      <= 1'b0;
              dont_walk_q <= 1'b1;
              half_q      <= '0;
            end else begin
              state_q     <= S_COOLDOWN;
              cnt_q       <= COOL_LOAD;
              dont_walk_q <= 1'b1;
              ped_req_q   <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
            if (state_q == S_FLASH) begin
              if (half_q == HALF_LAST) begin
                half_q      <= '0;
                dont_walk_q <= ~dont_walk_q;
              end else begin
                half_q <= half_q + 1'b1;
              end
            end
          end
        end

        S_COOLDOWN: begin
          if (cnt_q == '0) begin
            // A press landing on the expiry cycle still counts as pending.
            if (pending_q || press_q) begin
              state_q   <= S_REQ;
              ped_req_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
            pending_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            if (press_q) begin
              pending_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q     <= S_IDLE;
          cnt_q       <= '0;
          ped_req_q   <= 1'b0;
          walk_q      <= 1'b0;
          dont_walk_q <= 1'b1;
          pending_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ped_req     = ped_req_q;
  assign walk        = walk_q;
  assign dont_walk   = dont_walk_q;
  assign countdown   = cnt_q;
  assign req_pending = pending_q;
  assign abort       = abort_q;

`ifdef PED_TIMEOUT_EN
  assign req_timeout = timeout_q;
`else
  assign req_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ped_crossing.sv
// Testbench for ped_crossing: directed crossing scenarios followed by a long
// randomized run, every cycle compared against a time-based behavioural model.

module tb_ped_crossing;

  localparam int DEB   = 4;
  localparam int WALKC = 20;
  localparam int FLSH  = 10;
  localparam int HALF  = 2;
  localparam int COOL  = 30;
  localparam int TMO   = 64;
  localparam int CW    = 8;

  localparam logic [2:0] RED    = 3'b011;
  localparam logic [2:0] YELLOW = 3'b001;
  localparam logic [2:0] GREEN  = 3'b100;

  // {ped_req, walk, dont_walk, countdown[7:0], req_pending, abort, req_timeout}
  localparam logic [31:0] RESET_VEC = 32'h0000_0800;

`ifdef PED_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          btn = 1'b0;
  logic [2:0]    light_state = GREEN;
  logic          ped_req;
  logic          walk;
  logic          dont_walk;
  logic [CW-1:0] countdown;
  logic          req_pending;
  logic          abort;
  logic          req_timeout;

  ped_crossing #(
    .DEBOUNCE_CYC(DEB),
    .WALK_CYC    (WALKC),
    .FLASH_CYC   (FLSH),
    .FLASH_HALF  (HALF),
    .COOLDOWN_CYC(COOL),
    .REQ_TIMEOUT (TMO),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (btn),
    .light_state(light_state),
    .ped_req    (ped_req),
    .walk       (walk),
    .dont_walk  (dont_walk),
    .countdown  (countdown),
    .req_pending(req_pending),
    .abort      (abort),
    .req_timeout(req_timeout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", tag, $time, got, want);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: phase name plus cycles elapsed in that phase. Lamp values
  // and countdown are derived from elapsed time; the button is modelled as the
  // length of the current run of 1s, with a press reaching the crossing logic
  // three edges after the run first hits DEBOUNCE length (sync + pulse reg).
  // ---------------------------------------------------------------------------
  typedef enum {M_IDLE, M_REQ, M_WALK, M_FLASH, M_COOL} mphase_t;

  mphase_t m_ph;
  int      m_t;
  bit      m_pend, m_abort, m_tmo;
  int      m_run;
  bit      m_f1, m_f2, m_f3;

  function automatic void model_reset();
    m_ph = M_IDLE; m_t = 0; m_pend = 0; m_abort = 0; m_tmo = 0;
    m_run = 0; m_f1 = 0; m_f2 = 0; m_f3 = 0;
  endfunction

  function automatic void enter(input mphase_t p);
    m_ph = p;
    m_t  = 0;
  endfunction

  function automatic void model_edge(input logic b, input logic [2:0] l);
    bit press;
    bit red;
    press = m_f3;
    red   = (l == RED);
    m_f3 = m_f2;
    m_f2 = m_f1;
    if (b) begin
      if (m_run <= DEB) m_run++;
    end else begin
      m_run = 0;
    end
    m_f1 = (m_run == DEB);
    m_abort = 0;
    m_tmo   = 0;
    case (m_ph)
      M_IDLE: if (press) enter(M_REQ);
      M_REQ: begin
        if (red) enter(M_WALK);
        else if (TMO_ON && m_t == TMO - 1) begin enter(M_IDLE); m_tmo = 1; end
        else m_t++;
      end
      M_WALK, M_FLASH: begin
        if (!red) begin
          enter(M_COOL); m_abort = 1; m_pend = press;
        end else if (m_t == ((m_ph == M_WALK) ? WALKC : FLSH) - 1) begin
          enter((m_ph == M_WALK) ? M_FLASH : M_COOL);
        end else begin
          m_t++;
        end
      end
      M_COOL: begin
        if (press) m_pend = 1;
        if (m_t == COOL - 1) begin
          enter(m_pend ? M_REQ : M_IDLE);
          m_pend = 0;
        end else begin
          m_t++;
        end
      end
      default: enter(M_IDLE);
    endcase
  endfunction

  function automatic logic [31:0] model_vec();
    logic ped, wk, dw;
    int   cd;
    ped = 0; wk = 0; dw = 1; cd = 0;
    case (m_ph)
      M_REQ:   ped = 1;
      M_WALK:  begin ped = 1; wk = 1; dw = 0; cd = WALKC - 1 - m_t; end
      M_FLASH: begin ped = 1; dw = ((m_t / HALF) % 2 == 0); cd = FLSH - 1 - m_t; end
      M_COOL:  cd = COOL - 1 - m_t;
      default: ;
    endcase
    return {18'b0, ped, wk, dw, 8'(cd), m_pend, m_abort, m_tmo};
  endfunction

  function automatic logic [31:0] obs_vec();
    return {18'b0, ped_req, walk, dont_walk, countdown, req_pending, abort, req_timeout};
  endfunction

  // One clock: drive inputs, advance model on the edge, compare 1 unit later.
  task automatic cyc(input logic b, input logic [2:0] l);
    btn = b;
    light_state = l;
    @(posedge clk);
    if (rst_n) model_edge(b, l);
    else model_reset();
    #1;
    check("cyc", obs_vec(), model_vec());
  endtask

  initial begin
    int lat, rises, walk_cnt, fl_n, first_cd, zero_j, req_j, tmo_j, tmo_cnt;
    bit prev, got_walk, cool_seen, pend_seen, ped_at_tmo, did_rst, bval;
    logic [9:0] fl_pat;
    logic [2:0] lcur;
    int lseg, bseg;

    model_reset();
    rst_n = 1'b0;

    // Reset held with the button toggling.
    for (int i = 0; i < 6; i++) cyc(i[0], GREEN);
    check("rst_vals", obs_vec(), RESET_VEC);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1'b0, GREEN);
    check("idle_after_rst", obs_vec(), RESET_VEC);

    // Debounce: short bounce, then a long hold -> one request.
    for (int i = 0; i < 3; i++) cyc(1'b1, GREEN);
    for (int i = 0; i < 2; i++) cyc(1'b0, GREEN);
    lat = -1; rises = 0; prev = ped_req;
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b1, GREEN);
      if (ped_req && !prev) begin
        rises++;
        if (lat < 0) lat = i;
      end
      prev = ped_req;
    end
    check("deb_latency", 32'(lat), 32'(7));
    check("deb_one_req", 32'(rises), 32'(1));

    // Nominal crossing: WALK, FLASH, cooldown entry.
    walk_cnt = 0; fl_n = 0; fl_pat = '0; first_cd = -1; got_walk = 0; cool_seen = 0;
    for (int i = 0; i < 31; i++) begin
      cyc(1'b0, RED);
      if (walk) begin
        if (!got_walk) first_cd = int'(countdown);
        got_walk = 1;
        walk_cnt++;
      end else if (got_walk && fl_n < FLSH) begin
        fl_pat = {fl_pat[8:0], dont_walk};
        fl_n++;
      end else if (fl_n == FLSH && !cool_seen) begin
        cool_seen = 1;
        check("cool_entry", 32'({ped_req, dont_walk, countdown}), 32'({1'b0, 1'b1, 8'(COOL - 1)}));
      end
    end
    check("walk_len", 32'(walk_cnt), 32'(WALKC));
    check("walk_first_cd", 32'(first_cd), 32'(WALKC - 1));
    check("flash_pattern", 32'(fl_pat), 32'(10'b1100110011));
    check("cool_reached", 32'(cool_seen), 32'(1));

    // Press during cooldown -> pending, request right after expiry.
    pend_seen = 0; zero_j = -1; req_j = -1;
    for (int j = 1; j <= 34; j++) begin
      cyc(j <= 8, GREEN);
      if (req_pending) pend_seen = 1;
      if (countdown == '0 && !ped_req && zero_j < 0) zero_j = j;
      if (ped_req && req_j < 0) req_j = j;
    end
    check("cool_pending", 32'(pend_seen), 32'(1));
    check("cool_req_gap", 32'(req_j - zero_j), 32'(1));

    // Abort: RED lost in the middle of WALK.
    for (int k = 0; k < 8; k++) cyc(1'b0, RED);
    cyc(1'b0, GREEN);
    check("abort_vec", 32'({walk, dont_walk, abort, ped_req, countdown}),
          32'({1'b0, 1'b1, 1'b1, 1'b0, 8'(COOL - 1)}));
    cyc(1'b0, GREEN);
    check("abort_pulse_len", 32'(abort), 32'(0));
    for (int k = 0; k < 32; k++) cyc(1'b0, GREEN);

`ifdef PED_TIMEOUT_EN
    // Request never granted -> timeout pulse 64 cycles after REQ entry.
    req_j = -1; tmo_j = -1; tmo_cnt = 0; ped_at_tmo = 1;
    for (int j = 1; j <= 100; j++) begin
      cyc(j <= 6, GREEN);
      if (ped_req && req_j < 0) req_j = j;
      if (req_timeout) begin
        tmo_cnt++;
        if (tmo_j < 0) begin tmo_j = j; ped_at_tmo = ped_req; end
      end
    end
    check("tmo_gap", 32'(tmo_j - req_j), 32'(TMO));
    check("tmo_count", 32'(tmo_cnt), 32'(1));
    check("tmo_ped_drop", 32'(ped_at_tmo), 32'(0));
`endif

    // Randomized run with one asynchronous reset landing mid-crossing.
    lseg = 0; bseg = 0; lcur = GREEN; bval = 0; did_rst = 0;
    for (int n = 0; n < 4000; n++) begin
      if (lseg == 0) begin
        case ($urandom_range(0, 5))
          0, 1, 2: lcur = RED;
          3:       lcur = GREEN;
          4:       lcur = YELLOW;
          default: lcur = 3'($urandom_range(0, 7));
        endcase
        lseg = $urandom_range(1, 60);
      end
      if (bseg == 0) begin
        bval = ($urandom_range(0, 2) == 0);
        bseg = $urandom_range(1, 12);
      end
      lseg--;
      bseg--;
      if (!did_rst && n >= 1500 && (m_ph == M_WALK || m_ph == M_FLASH || n == 3500)) begin
        did_rst = 1;
        #2 rst_n = 1'b0;
        #1 model_reset();
        check("async_rst", obs_vec(), RESET_VEC);
        for (int k = 0; k < 3; k++) cyc(bval, lcur);
        #3 rst_n = 1'b1;
      end
      cyc(bval, lcur);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
